// File: rtl/coproc_pkg.sv
// Shared constants for the multiply/divide/shift coprocessor: opcodes,
// shift formats, FSM state encoding and the ID word.
package coproc_pkg;

  localparam logic [3:0] OP_STATUS = 4'h0;
  localparam logic [3:0] OP_ID     = 4'h1;
  localparam logic [3:0] OP_PHI    = 4'h2;
  localparam logic [3:0] OP_PLO    = 4'h3;
  localparam logic [3:0] OP_QUO    = 4'h4;
  localparam logic [3:0] OP_REM    = 4'h5;
  localparam logic [3:0] OP_SHI    = 4'h6;
  localparam logic [3:0] OP_SLO    = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_DIV    = 4'h9;
  localparam logic [3:0] OP_SHF    = 4'hA;

  localparam logic [1:0] FMT_LSL = 2'b00;
  localparam logic [1:0] FMT_LSR = 2'b01;
  localparam logic [1:0] FMT_ASR = 2'b10;
  localparam logic [1:0] FMT_ROL = 2'b11;

  localparam logic [7:0] ID_CONST = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_SHF  = 3'd3,
    ST_FIX  = 3'd4
  } state_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_SHF);
  endfunction

endpackage

// File: rtl/mds_core.sv
// Sequencer and shared datapath: bit-serial multiply, restoring divide and
// one-bit-per-cycle double-cell shifter, plus the result registers.
module mds_core
  import coproc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 6
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic               sgn,
  input  logic [1:0]         fmt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output state_e             state_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic [2*WIDTH-1:0] shf_o,
  output logic               ovf_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNTW:0]    CNT_ONE = (CNTW+1)'(1);
  localparam logic [CNTW:0]    CNT_W   = (CNTW+1)'(WIDTH);
  localparam logic [CNTW:0]    CNT_2W  = (CNTW+1)'(W2);
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNTW:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [1:0]         fmt_q, fmt_d;
  logic               sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0]   opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, braw_q, braw_d;
  logic [W2-1:0]      prod_q, prod_d, shf_q, shf_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic               ovf_q, ovf_d;

  // Capture-time operand conditioning
  logic [WIDTH-1:0] a_mag, b_mag, c_mag;
  logic [W2-1:0]    dvd_mag;
  logic [CNTW:0]    cnt_raw, shf_cnt;

  always_comb begin
    a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag   = (sgn && b[WIDTH-1]) ? -b : b;
    c_mag   = (sgn && c[WIDTH-1]) ? -c : c;
    dvd_mag = (sgn && a[WIDTH-1]) ? -{a, b} : {a, b};
    cnt_raw = {1'b0, c[CNTW-1:0]};
    if (fmt == FMT_ROL) shf_cnt = cnt_raw % CNT_2W;
    else                shf_cnt = (cnt_raw >= CNT_2W) ? CNT_2W : cnt_raw;
  end

  // One adder serves both MUL (hi + multiplicand) and DIV (partial rem - divisor)
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] sum;

  always_comb begin
    add_x   = {1'b0, hi_q};
    add_y   = {1'b0, opd_q};
    add_cin = 1'b0;
    if (state_q == ST_DIV) begin
      add_x   = {hi_q, lo_q[WIDTH-1]};
      add_y   = ~{1'b0, opd_q};
      add_cin = 1'b1;
    end
    sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  logic [WIDTH:0]   mul_s;
  logic [W2-1:0]    acc, acc_sh;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             q_ovf;

  always_comb begin
    mul_s = lo_q[0] ? sum[WIDTH:0] : {1'b0, hi_q};
    acc   = {hi_q, lo_q};
    case (fmt_q)
      FMT_LSL: acc_sh = {acc[W2-2:0], 1'b0};
      FMT_LSR: acc_sh = {1'b0, acc[W2-1:1]};
      FMT_ASR: acc_sh = {acc[W2-1], acc[W2-1:1]};
      default: acc_sh = {acc[W2-2:0], acc[W2-1]};
    endcase
    q_fix = neg_q  ? -lo_q : lo_q;
    r_fix = rneg_q ? -hi_q : hi_q;
    // Negative quotients may reach -2^(W-1); positive ones stop one short
    q_ovf = sgn_q && (neg_q ? (lo_q > SMIN) : lo_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fmt_d   = fmt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    braw_d  = braw_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          fmt_d = fmt;
          sgn_d = sgn;
          if (op == OP_MUL) begin
            state_d = ST_MUL;
            opd_d   = a_mag;
            hi_d    = '0;
            lo_d    = b_mag;
            neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_d   = CNT_W;
            ovf_d   = 1'b0;
          end else if (op == OP_DIV) begin
            state_d       = ST_DIV;
            opd_d         = c_mag;
            {hi_d, lo_d}  = dvd_mag;
            neg_d         = sgn && (a[WIDTH-1] ^ c[WIDTH-1]);
            rneg_d        = sgn && a[WIDTH-1];
            // Covers c == 0 as well: quotient would not fit in one cell
            dz_d          = (dvd_mag[W2-1:WIDTH] >= c_mag);
            braw_d        = b;
            cnt_d         = CNT_W;
            ovf_d         = 1'b0;
          end else begin
            state_d      = ST_SHF;
            {hi_d, lo_d} = {a, b};
            cnt_d        = shf_cnt;
          end
        end
      end
      ST_MUL: begin
        hi_d  = mul_s[WIDTH:1];
        lo_d  = {mul_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (dz_q) begin
          state_d = ST_FIX;
        end else begin
          hi_d  = sum[WIDTH+1] ? sum[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_d  = {lo_q[WIDTH-2:0], sum[WIDTH+1]};
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_d = ST_FIX;
        end
      end
      ST_SHF: begin
        if (cnt_q != '0) begin
          {hi_d, lo_d} = acc_sh;
          cnt_d        = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (op_q == OP_MUL) begin
          prod_d = neg_q ? -acc : acc;
        end else if (op_q == OP_DIV) begin
          if (dz_q) begin
            quo_d = '1;
            rem_d = braw_q;
            ovf_d = 1'b1;
          end else begin
            quo_d = q_fix;
            rem_d = r_fix;
            ovf_d = q_ovf;
          end
        end else begin
          shf_d = acc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      fmt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      braw_q  <= '0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      shf_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fmt_q   <= fmt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      braw_q  <= braw_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state_o = state_q;
  assign prod_o  = prod_q;
  assign quo_o   = quo_q;
  assign rem_o   = rem_q;
  assign shf_o   = shf_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/coproc_mds.sv
// Coprocessor top: decodes go/sel into starts and reads, keeps the
// collision flag and the registered read port y.
module coproc_mds
  import coproc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [10:0]      sel,
  input  logic             go,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c
);

  logic [3:0] op;
  logic       sgn;
  logic [1:0] fmt;
  logic       unused_sel;

  assign op         = sel[3:0];
  assign sgn        = sel[4];
  assign fmt        = sel[7:6];
  assign unused_sel = ^{sel[10:8], sel[5]};

  state_e             core_state;
  logic [2*WIDTH-1:0] prod, shf;
  logic [WIDTH-1:0]   quo, rem;
  logic               ovf;
  logic               is_start, start;

  assign busy     = (core_state != ST_IDLE);
  assign is_start = go && is_start_op(op);
  assign start    = is_start && !busy;

  mds_core #(.WIDTH(WIDTH), .CNTW(CNTW)) u_core (
    .clk     (clk),
    .arstn   (arstn),
    .start   (start),
    .op      (op),
    .sgn     (sgn),
    .fmt     (fmt),
    .a       (a),
    .b       (b),
    .c       (c),
    .state_o (core_state),
    .prod_o  (prod),
    .quo_o   (quo),
    .rem_o   (rem),
    .shf_o   (shf),
    .ovf_o   (ovf)
  );

  logic             collision_q, collision_d;
  logic [WIDTH-1:0] y_q, y_d, rd_word;

  always_comb begin
    rd_word = '0;
    case (op)
      OP_STATUS: rd_word = WIDTH'({collision_q, ovf, busy});
      OP_ID:     rd_word = WIDTH'(ID_CONST);
      OP_PHI:    rd_word = prod[2*WIDTH-1:WIDTH];
      OP_PLO:    rd_word = prod[WIDTH-1:0];
      OP_QUO:    rd_word = quo;
      OP_REM:    rd_word = rem;
      OP_SHI:    rd_word = shf[2*WIDTH-1:WIDTH];
      OP_SLO:    rd_word = shf[WIDTH-1:0];
      default:   rd_word = '0;
    endcase
  end

  // A status read and a rejected start cannot share one go, so order is moot
  always_comb begin
    collision_d = collision_q;
    y_d         = y_q;
    if (go && (op == OP_STATUS)) collision_d = 1'b0;
    if (is_start && busy)        collision_d = 1'b1;
    if (go && !is_start_op(op))  y_d = rd_word;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      collision_q <= 1'b0;
      y_q         <= '0;
    end else begin
      collision_q <= collision_d;
      y_q         <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_coproc_mds.sv
// Directed-vector bench for coproc_mds: reads push expected words into a
// scoreboard queue, a monitor compares y on the cycle after each read go.
module tb_coproc_mds;
  import coproc_pkg::*;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         arstn = 1'b0;
  logic [10:0]  sel   = '0;
  logic         go    = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] c     = '0;
  logic [W-1:0] y;
  logic         busy;

  coproc_mds #(.WIDTH(W), .CNTW(6)) dut (
    .clk   (clk),
    .arstn (arstn),
    .sel   (sel),
    .go    (go),
    .y     (y),
    .busy  (busy),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         rd_vld = 1'b0;
  logic [W-1:0] mon_exp;
  string        mon_name;

  always @(posedge clk) rd_vld <= go && !(sel[3:0] inside {4'h8, 4'h9, 4'hA});

  always @(negedge clk) begin
    if (rd_vld) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: y=%h with no expected value queued", y);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (y !== mon_exp) begin
          n_err++;
          $display("FAIL %s: y=%h expected %h", mon_name, y, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic [3:0] op, input logic sg, input logic [1:0] fmt,
                       input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tc);
    @(negedge clk);
    a   = ta;
    b   = tb_v;
    c   = tc;
    sel = {3'b000, fmt, 1'b0, sg, op};
    go  = 1'b1;
    @(negedge clk);
    go  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] op, input logic [W-1:0] exp_v, input string nm);
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    pulse(op, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // exp_cyc < 0 skips the latency comparison but still bounds the wait
  task automatic wait_idle(input int exp_cyc, input string nm);
    int cycles;
    cycles = 0;
    while (busy && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    n_vec++;
    if (busy || (exp_cyc >= 0 && cycles != exp_cyc)) begin
      n_err++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected idle after %0d", nm, busy, cycles, exp_cyc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {{(W-1){1'b0}}, busy}, '0);
    chk("reset_y", y, '0);
    arstn = 1'b1;

    rd(OP_STATUS, 16'h0000, "rst_status");
    rd(OP_ID,     16'h0008, "id");
    rd(OP_PHI,    16'h0000, "rst_phi");
    rd(OP_PLO,    16'h0000, "rst_plo");
    rd(OP_QUO,    16'h0000, "rst_quo");
    rd(OP_REM,    16'h0000, "rst_rem");
    rd(OP_SHI,    16'h0000, "rst_shi");
    rd(OP_SLO,    16'h0000, "rst_slo");
    rd(4'hB,      16'h0000, "rd_zero_b");

    // unsigned multiply, full-scale
    pulse(OP_MUL, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000);
    chk("mul_busy", {{(W-1){1'b0}}, busy}, 16'h0001);
    wait_idle(17, "mul_lat");
    rd(OP_PHI, 16'hFFFE, "mul_hi");
    rd(OP_PLO, 16'h0001, "mul_lo");
    rd(OP_STATUS, 16'h0000, "mul_status");

    // signed multiply -3 * 5
    pulse(OP_MUL, 1'b1, 2'b00, 16'hFFFD, 16'h0005, 16'h0000);
    wait_idle(17, "smul_lat");
    rd(OP_PHI, 16'hFFFF, "smul_hi");
    rd(OP_PLO, 16'hFFF1, "smul_lo");

    // signed divide -100 / 7
    pulse(OP_DIV, 1'b1, 2'b00, 16'hFFFF, 16'hFF9C, 16'h0007);
    wait_idle(17, "sdiv_lat");
    rd(OP_QUO, 16'hFFF2, "sdiv_quo");
    rd(OP_REM, 16'hFFFE, "sdiv_rem");
    rd(OP_STATUS, 16'h0000, "sdiv_status");

    // unsigned 65536 / 256
    pulse(OP_DIV, 1'b0, 2'b00, 16'h0001, 16'h0000, 16'h0100);
    wait_idle(17, "udiv_lat");
    rd(OP_QUO, 16'h0100, "udiv_quo");
    rd(OP_REM, 16'h0000, "udiv_rem");

    // divide by zero
    pulse(OP_DIV, 1'b0, 2'b00, 16'h0000, 16'h1234, 16'h0000);
    wait_idle(2, "dz_lat");
    rd(OP_QUO, 16'hFFFF, "dz_quo");
    rd(OP_REM, 16'h1234, "dz_rem");
    rd(OP_STATUS, 16'h0002, "dz_status");

    // unsigned overflow a >= c
    pulse(OP_DIV, 1'b0, 2'b00, 16'h0005, 16'h00AA, 16'h0005);
    wait_idle(2, "dovf_lat");
    rd(OP_QUO, 16'hFFFF, "dovf_quo");
    rd(OP_REM, 16'h00AA, "dovf_rem");
    rd(OP_STATUS, 16'h0002, "dovf_status");

    // a new multiply clears overflow; status mid-run shows only busy
    pulse(OP_MUL, 1'b0, 2'b00, 16'h0002, 16'h0003, 16'h0000);
    rd(OP_STATUS, 16'h0001, "mul_run_status");
    wait_idle(-1, "mul2_done");
    rd(OP_PHI, 16'h0000, "mul2_hi");
    rd(OP_PLO, 16'h0006, "mul2_lo");
    rd(OP_STATUS, 16'h0000, "mul2_status");

    // shifts
    pulse(OP_SHF, 1'b0, FMT_ASR, 16'h8000, 16'h0000, 16'd4);
    wait_idle(5, "asr_lat");
    rd(OP_SHI, 16'hF800, "asr_hi");
    rd(OP_SLO, 16'h0000, "asr_lo");

    pulse(OP_SHF, 1'b0, FMT_ROL, 16'h8000, 16'h0001, 16'd33);
    wait_idle(2, "rol_lat");
    rd(OP_SHI, 16'h0000, "rol_hi");
    rd(OP_SLO, 16'h0003, "rol_lo");

    pulse(OP_SHF, 1'b0, FMT_LSL, 16'h1234, 16'h5678, 16'd0);
    wait_idle(2, "sh0_lat");
    rd(OP_SHI, 16'h1234, "sh0_hi");
    rd(OP_SLO, 16'h5678, "sh0_lo");

    pulse(OP_SHF, 1'b0, FMT_LSR, 16'hFFFF, 16'hFFFF, 16'd40);
    wait_idle(33, "lsr_sat_lat");
    rd(OP_SHI, 16'h0000, "lsr_sat_hi");
    rd(OP_SLO, 16'h0000, "lsr_sat_lo");

    pulse(OP_SHF, 1'b0, FMT_LSL, 16'h8000, 16'h0001, 16'd1);
    wait_idle(2, "lsl1_lat");
    rd(OP_SHI, 16'h0000, "lsl1_hi");
    rd(OP_SLO, 16'h0002, "lsl1_lo");
    rd(OP_PLO, 16'h0006, "prod_retained");

    // collision: multiply start during a divide
    pulse(OP_DIV, 1'b0, 2'b00, 16'h0000, 16'h03E8, 16'h0007);
    pulse(OP_MUL, 1'b0, 2'b00, 16'h0001, 16'h0001, 16'h0000);
    wait_idle(-1, "coll_done");
    rd(OP_QUO, 16'h008E, "coll_quo");
    rd(OP_REM, 16'h0006, "coll_rem");
    rd(OP_PLO, 16'h0006, "coll_prod_kept");
    rd(OP_STATUS, 16'h0004, "coll_status");
    rd(OP_STATUS, 16'h0000, "coll_cleared");

    // reset mid-multiply
    pulse(OP_MUL, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000);
    repeat (5) @(negedge clk);
    arstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", {{(W-1){1'b0}}, busy}, '0);
    arstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", {{(W-1){1'b0}}, busy}, '0);
    rd(OP_STATUS, 16'h0000, "abort_status");
    rd(OP_PHI,    16'h0000, "abort_phi");
    rd(OP_PLO,    16'h0000, "abort_plo");
    rd(OP_QUO,    16'h0000, "abort_quo");
    rd(OP_REM,    16'h0000, "abort_rem");
    rd(OP_SHI,    16'h0000, "abort_shi");
    rd(OP_SLO,    16'h0000, "abort_slo");

    // final report
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected reads left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
